// File: rtl/traffic_rr_ctrl.sv
// traffic_rr_ctrl: N-direction intersection light controller.
// One central FSM grants green to one direction at a time. The next owner is
// the first direction with demand, searched round-robin from owner+1. The
// controller rests in green on PRIO_DIR when there is no demand.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   T      per-direction traffic-present sensor
//   L      per-direction light, L[2i+1:2i]: 0 green, 1 yellow, 2 red
//   owner  direction currently or last granted
//   phase  0 GREEN, 1 YELLOW, 2 ALL_RED
module traffic_rr_ctrl #(
    parameter int unsigned N_DIR     = 4,
    parameter int unsigned GREEN_MIN = 3,
    parameter int unsigned GREEN_MAX = 6,
    parameter int unsigned YELLOW_T  = 2,
    parameter int unsigned ALLRED_T  = 1,
    parameter int unsigned PRIO_DIR  = 0,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_DIR-1:0]           T,
    output logic [2*N_DIR-1:0]         L,
    output logic [$clog2(N_DIR)-1:0]   owner,
    output logic [1:0]                 phase
);

    localparam int unsigned OW = $clog2(N_DIR);

    localparam logic [1:0] ST_GREEN  = 2'd0;
    localparam logic [1:0] ST_YELLOW = 2'd1;
    localparam logic [1:0] ST_ALLRED = 2'd2;

    localparam logic [1:0] LT_GREEN  = 2'd0;
    localparam logic [1:0] LT_YELLOW = 2'd1;
    localparam logic [1:0] LT_RED    = 2'd2;

    localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ARED_M1 = CNT_W'(ALLRED_T - 1);

    localparam logic [OW-1:0] PRIO      = OW'(PRIO_DIR);
    localparam logic [OW-1:0] OWNER_RST = OW'((PRIO_DIR + N_DIR - 1) % N_DIR);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [2*N_DIR-1:0] l_q, l_d;

    logic [OW-1:0]      next_owner;
    logic               found;
    logic [N_DIR-1:0]   own_mask;
    logic               competing;
    logic               green_done;

    // Round-robin pick: first demanding direction from owner+1; owner itself last.
    always_comb begin
        next_owner = PRIO;
        found      = 1'b0;
        for (int unsigned k = 1; k <= N_DIR; k++) begin
            if (!found && T[OW'((32'(owner_q) + k) % N_DIR)]) begin
                next_owner = OW'((32'(owner_q) + k) % N_DIR);
                found      = 1'b1;
            end
        end
    end

    // Green exit: after min green, yield to competing demand, or return to rest.
    always_comb begin
        own_mask   = N_DIR'(1) << owner_q;
        competing  = |(T & ~own_mask);
        green_done = (cnt_q >= GMIN_M1) &&
                     ((competing && (!T[owner_q] || (cnt_q == GMAX_M1))) ||
                      ((T == '0) && (owner_q != PRIO)));
    end

    // Next-state, counter, owner and light decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        owner_d = owner_q;
        l_d     = {N_DIR{LT_RED}};

        case (state_q)
            ST_ALLRED: begin
                if (cnt_q == ARED_M1) begin
                    state_d = ST_GREEN;
                    cnt_d   = '0;
                    owner_d = next_owner;
                end
            end
            ST_GREEN: begin
                // Saturate so the max-green compare stays valid while resting.
                if (cnt_q == GMAX_M1) begin
                    cnt_d = cnt_q;
                end
                if (green_done) begin
                    state_d = ST_YELLOW;
                    cnt_d   = '0;
                end
            end
            ST_YELLOW: begin
                if (cnt_q == YEL_M1) begin
                    state_d = ST_ALLRED;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_ALLRED;
                cnt_d   = '0;
            end
        endcase

        for (int unsigned i = 0; i < N_DIR; i++) begin
            if (OW'(i) == owner_d) begin
                if (state_d == ST_GREEN) begin
                    l_d[2*i +: 2] = LT_GREEN;
                end else if (state_d == ST_YELLOW) begin
                    l_d[2*i +: 2] = LT_YELLOW;
                end
            end
        end
    end

    // State registers; lights registered from the decoded next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_ALLRED;
            cnt_q   <= '0;
            owner_q <= OWNER_RST;
            l_q     <= {N_DIR{LT_RED}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            l_q     <= l_d;
        end
    end

    assign L     = l_q;
    assign owner = owner_q;
    assign phase = state_q;

endmodule

// File: tb/tb_traffic_rr_ctrl.sv
// Bench for traffic_rr_ctrl with default parameters: a phase/duration model
// checked every cycle, light invariants, and directed scenario checks.
module tb_traffic_rr_ctrl;

    localparam int N    = 4;
    localparam int GMIN = 3;
    localparam int GMAX = 6;
    localparam int YT   = 2;
    localparam int ART  = 1;
    localparam int PRIO = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] T   = 4'b0;
    logic [7:0] L;
    logic [1:0] owner;
    logic [1:0] phase;

    always #5 clk = ~clk;

    traffic_rr_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .T     (T),
        .L     (L),
        .owner (owner),
        .phase (phase)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_ph: 0 green, 1 yellow, 2 all-red; m_t: cycles already spent in phase.
    int m_ph  = 2;
    int m_t   = 0;
    int m_own = (PRIO + N - 1) % N;

    function automatic int pick(input int own, input logic [3:0] t);
        for (int k = 1; k <= N; k++) begin
            if (t[(own + k) % N]) return (own + k) % N;
        end
        return PRIO;
    endfunction

    task automatic model_step(input logic [3:0] t);
        int   el;
        logic others;
        el     = m_t + 1;
        others = (t & ~(4'b1 << m_own)) != 4'b0;
        case (m_ph)
            2: if (el >= ART) begin m_own = pick(m_own, t); m_ph = 0; m_t = 0; end
               else m_t = el;
            0: if (el >= GMIN && ((others && (!t[m_own] || el >= GMAX)) ||
                                  (t == 4'b0 && m_own != PRIO))) begin
                   m_ph = 1; m_t = 0;
               end else m_t = el;
            default: if (el >= YT) begin m_ph = 2; m_t = 0; end
                     else m_t = el;
        endcase
    endtask

    function automatic logic [7:0] exp_lights(input int ph, input int own);
        logic [7:0] v;
        v = 8'hAA;
        for (int i = 0; i < N; i++) begin
            if (i == own && ph != 2) v[2*i +: 2] = (ph == 0) ? 2'd0 : 2'd1;
        end
        return v;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph = 2; m_t = 0; m_own = (PRIO + N - 1) % N;
        end else begin
            model_step(T);
        end
    end

    // ---------------- per-cycle compare + invariants ----------------
    logic [7:0] prev_L = 8'hAA;

    always @(negedge clk) begin : cmp
        int   nonred;
        logic bad3, g2r, r2y;
        logic [1:0] f, pf;
        check("model_L", L, exp_lights(m_ph, m_own));
        check("model_phase", phase, m_ph);
        check("model_owner", owner, m_own);
        nonred = 0; bad3 = 1'b0; g2r = 1'b0; r2y = 1'b0;
        for (int i = 0; i < N; i++) begin
            f  = L[2*i +: 2];
            pf = prev_L[2*i +: 2];
            if (f != 2'd2) nonred++;
            if (f == 2'd3) bad3 = 1'b1;
            if (rst && pf == 2'd0 && f == 2'd2) g2r = 1'b1;
            if (rst && pf == 2'd2 && f == 2'd1) r2y = 1'b1;
        end
        check("inv_one_nonred", 32'(nonred <= 1), 1);
        check("inv_no_3", 32'(bad3), 0);
        check("inv_no_green_to_red", 32'(g2r), 0);
        check("inv_no_red_to_yellow", 32'(r2y), 0);
        prev_L = rst ? L : 8'hAA;
    end

    // ---------------- green interval monitor ----------------
    int   cyc = 0;
    logic was_green = 1'b0;
    int   cur_len = 0, cur_own = 0, cur_start = 0;
    int   q_own[$], q_len[$], q_start[$];

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            was_green = 1'b0;
        end else if (phase == 2'd0) begin
            if (!was_green) begin
                cur_len = 0; cur_own = int'(owner); cur_start = cyc;
            end
            cur_len++;
            was_green = 1'b1;
        end else begin
            if (was_green) begin
                q_own.push_back(cur_own); q_len.push_back(cur_len); q_start.push_back(cur_start);
            end
            was_green = 1'b0;
        end
    end

    task automatic clear_q();
        q_own.delete(); q_len.delete(); q_start.delete();
    endtask

    // Act 1 time unit after the falling edge so all monitors have settled.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_green(input int own, input int max, output int cycles);
        cycles = 0;
        while (cycles < max && !(phase == 2'd0 && int'(owner) == own)) begin
            tick(1);
            cycles++;
        end
        check("wait_green_timeout", 32'(phase == 2'd0 && int'(owner) == own), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst = 1'b0; T = 4'b0;
        tick(3);
        check("rst_L", L, 8'hAA);
        check("rst_phase", phase, 2);
        check("rst_owner", owner, 3);

        // Idle release: one all-red cycle, then rest green on dir0.
        rst = 1'b1;
        tick(1);
        check("idle_L", L, 8'hA8);
        check("idle_owner", owner, 0);
        tick(50);
        check("idle_hold_L", L, 8'hA8);
        check("idle_hold_phase", phase, 0);

        // Single demand on dir2.
        T = 4'b0100;
        wait_green(2, 20, c);
        check("dir2_latency", c, 4);
        check("dir2_L", L, 8'h8A);
        check("dir2_owner", owner, 2);

        // Demand drops on green entry: min green, then back to rest.
        T = 4'b0000;
        wait_green(0, 20, c);
        check("back_to_rest_latency", c, 6);
        if (q_own.size() > 0) begin
            check("dir2_green_owner", q_own[$], 2);
            check("dir2_green_len", q_len[$], 3);
        end else check("dir2_green_recorded", 0, 1);

        // Max-green alternation between dir0 and dir1.
        clear_q();
        T = 4'b0011;
        tick(36);
        if (q_own.size() >= 3) begin
            check("max0_owner", q_own[0], 0); check("max0_len", q_len[0], 6);
            check("max1_owner", q_own[1], 1); check("max1_len", q_len[1], 6);
            check("max2_owner", q_own[2], 0); check("max2_len", q_len[2], 6);
            for (int i = 0; i < q_own.size(); i++) check("max_no_dir23", 32'(q_own[i] < 2), 1);
        end else check("max_green_count", q_own.size(), 3);

        // Full round-robin with all directions demanding.
        clear_q();
        T = 4'b1111;
        tick(100);
        if (q_own.size() >= 7) begin
            check("rr_first_owner", q_own[0], 0);
            for (int i = 1; i <= 6; i++) begin
                check("rr_order", q_own[i], (q_own[i-1] + 1) % N);
                check("rr_len", q_len[i], 6);
            end
            check("rr_period", q_start[5] - q_start[1], 36);
        end else check("rr_green_count", q_own.size(), 7);

        // Min green: dir1 loses its demand on entry while dir3 demands.
        T = 4'b0001;
        wait_green(0, 60, c);
        T = 4'b0010;
        wait_green(1, 30, c);
        T = 4'b1000;
        clear_q();
        wait_green(3, 30, c);
        check("min_latency", c, 6);
        if (q_own.size() > 0) begin
            check("min_owner", q_own[0], 1);
            check("min_len", q_len[0], 3);
        end else check("min_green_recorded", 0, 1);

        // Asynchronous reset in the middle of yellow.
        T = 4'b0001;
        c = 0;
        while (c < 30 && phase != 2'd1) begin tick(1); c++; end
        check("reach_yellow", phase, 1);
        #1 rst = 1'b0;
        #1;
        check("async_rst_L", L, 8'hAA);
        check("async_rst_phase", phase, 2);
        check("async_rst_owner", owner, 3);
        tick(2);
        T = 4'b0000;
        rst = 1'b1;
        tick(1);
        check("restart_L", L, 8'hA8);
        tick(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
